// File: rtl/mem_access_unit_pkg.sv
// Shared types for the M-stage memory access unit: width codes, exception codes,
// FSM states and the lane helpers used to build bus transactions.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        WidthWord = 2'b00,
        WidthHalf = 2'b01,
        WidthByte = 2'b10,
        WidthIll  = 2'b11
    } width_e;

    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcDBE  = 5'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic       we;
        logic       sign;
        width_e     width;
        logic [1:0] addr_lo;
    } req_t;

    function automatic logic is_misaligned(width_e w, logic [1:0] lo);
        case (w)
            WidthWord: return lo != 2'b00;
            WidthHalf: return lo[0];
            WidthByte: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(width_e w, logic [1:0] lo);
        case (w)
            WidthWord: return 4'b1111;
            WidthHalf: return lo[1] ? 4'b1100 : 4'b0011;
            WidthByte: return 4'b0001 << lo;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(width_e w, logic [31:0] d);
        case (w)
            WidthHalf: return {2{d[15:0]}};
            WidthByte: return {4{d[7:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed half/byte lane out of a full bus word and sign- or
// zero-extends it to 32 bits; word reads pass straight through.
module load_align_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] bus_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  width_e      width_i,
    input  logic        load_sign_i,
    output logic [31:0] data_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign half_v = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        unique case (addr_lo_i)
            2'd0: byte_v = bus_rdata_i[7:0];
            2'd1: byte_v = bus_rdata_i[15:8];
            2'd2: byte_v = bus_rdata_i[23:16];
            2'd3: byte_v = bus_rdata_i[31:24];
        endcase
    end

    always_comb begin
        case (width_i)
            WidthHalf: data_o = {{16{load_sign_i & half_v[15]}}, half_v};
            WidthByte: data_o = {{24{load_sign_i & byte_v[7]}}, byte_v};
            default:   data_o = bus_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory initiator: one word-aligned bus transaction per load/store.
// Define MEM_ACCESS_TIMEOUT_EN to raise DBE after WAIT_LIMIT unanswered REQ cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  width,
    input  logic        load_sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        exc_q, exc_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] load_value;
    width_e      width_in;

    assign width_in = width_e'(width);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_wait_limit;
    assign unused_wait_limit = ^WAIT_LIMIT;
`endif

    load_align_ext u_load_align_ext (
        .bus_rdata_i (bus_rdata),
        .addr_lo_i   (req_q.addr_lo),
        .width_i     (req_q.width),
        .load_sign_i (req_q.sign),
        .data_o      (load_value)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rd_data_d   = rd_data_q;
        exc_d       = exc_q;
        exc_code_d  = exc_code_q;
        stall       = 1'b0;
        done        = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    stall = 1'b1;
                    if (is_misaligned(width_in, addr[1:0])) begin
                        exc_d      = 1'b1;
                        exc_code_d = req_we ? ExcAdES : ExcAdEL;
                        state_d    = StDone;
                    end else begin
                        req_d       = '{we: req_we, sign: load_sign, width: width_in,
                                        addr_lo: addr[1:0]};
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = lane_be(width_in, addr[1:0]);
                        bus_wdata_d = lane_wdata(width_in, wdata);
                        exc_d       = 1'b0;
                        state_d     = StReq;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt_d  = '0;
`endif
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (bus_ready) begin
                    if (!req_q.we) begin
                        rd_data_d = load_value;
                    end
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = StDone;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (wait_cnt_q + 8'd1 == 8'(WAIT_LIMIT)) begin
                    // Responder never answered: abandon without touching rd_data.
                    exc_d      = 1'b1;
                    exc_code_d = ExcDBE;
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    state_d    = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            StDone: begin
                // req_valid here still belongs to the completing instruction.
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            exc_q       <= 1'b0;
            exc_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rd_data_q   <= rd_data_d;
            exc_q       <= exc_d;
            exc_code_q  <= exc_code_d;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_data   = rd_data_q;
    assign exc       = (state_q == StDone) && exc_q;
    assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts bus
// fields, latency and load results; a negedge monitor compares every cycle.
module tb_mem_access_unit;

    localparam int WaitLimit = 16;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, load_sign;
    logic [1:0]  width;
    logic [31:0] addr, wdata;
    logic        stall, done, exc;
    logic [31:0] rd_data;
    logic [4:0]  exc_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    int total = 0;
    int bad   = 0;

    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    bit          exp_exc;
    logic [4:0]  exp_code;
    logic [31:0] txn_rd, held_rd;
    int          exp_req, exp_lat;

    int          req_cycles, stall_cycles, done_cnt;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic [4:0]  seen_code;
    bit          chk_en;

    int          resp_wait, rcnt;
    logic [31:0] resp_rdata;
    bit          stray_ready;

    mem_access_unit #(.WAIT_LIMIT(WaitLimit)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .width     (width),
        .load_sign (load_sign),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .exc       (exc),
        .exc_code  (exc_code),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Lane value as an unsigned number, then two's-complement wrap when signed.
    function automatic logic [31:0] model_load(logic [1:0] w, bit sgn, logic [31:0] a,
                                               logic [31:0] rd);
        logic [31:0] lane, mask, v;
        lane = rd >> (8 * int'(a[1:0]));
        mask = (w == 2'b00) ? 32'hFFFF_FFFF : (w == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
        v    = lane & mask;
        if (w != 2'b00 && sgn && v > (mask >> 1)) v = v - mask - 32'd1;
        return v;
    endfunction

    task automatic setup(input bit we, input logic [1:0] w, input bit sgn, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
        bit misal;
        int off;
        off       = int'(a[1:0]);
        misal     = (w == 2'b11) || (w == 2'b00 && off != 0) || (w == 2'b01 && off % 2 != 0);
        exp_we    = we;
        exp_addr  = a & ~32'd3;
        exp_be    = (w == 2'b00) ? 4'hF : (w == 2'b01) ? 4'(3 << off) : 4'(1 << off);
        exp_wdata = (w == 2'b00) ? wd :
                    (w == 2'b01) ? (wd & 32'hFFFF) * 32'h0001_0001 : (wd & 32'hFF) * 32'h0101_0101;
        txn_rd    = held_rd;
        exp_exc   = 1'b0;
        exp_code  = 5'd0;
        if (misal) begin
            exp_exc  = 1'b1;
            exp_code = we ? 5'd5 : 5'd4;
            exp_req  = 0;
        end else if (TimeoutEn && wait_n >= WaitLimit) begin
            exp_exc  = 1'b1;
            exp_code = 5'd7;
            exp_req  = WaitLimit;
        end else begin
            exp_req = wait_n + 1;
            if (!we) txn_rd = model_load(w, sgn, a, rd);
        end
        exp_lat      = exp_req + 2;
        resp_wait    = wait_n;
        resp_rdata   = rd;
        req_cycles   = 0;
        stall_cycles = 0;
        done_cnt     = 0;
        req_we       = we;
        width        = w;
        load_sign    = sgn;
        addr         = a;
        wdata        = wd;
        req_valid    = 1'b1;
    endtask

    task automatic do_txn(input bit we, input logic [1:0] w, input bit sgn, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                          input string name);
        int cyc;
        setup(we, w, sgn, a, wd, rd, wait_n);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_req_cycles"}, req_cycles, exp_req);
        check({name, "_stall_cycles"}, stall_cycles, exp_lat - 1);
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    // Responder: answers after resp_wait REQ cycles; junk data on non-ready cycles.
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            if (rcnt == resp_wait) begin
                bus_ready = 1'b1;
                bus_rdata = resp_rdata;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 32'hDEAD_0000 + 32'(rcnt);
            end
            rcnt++;
        end else begin
            rcnt      = 0;
            bus_ready = stray_ready;
            bus_rdata = 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (stall) stall_cycles++;
            if (!req_valid) check("stall_idle", stall, 0);
            if (bus_req) begin
                req_cycles++;
                check("bus_we", bus_we, exp_we);
                check("bus_addr", bus_addr, exp_addr);
                check("bus_be", bus_be, exp_be);
                check("bus_wdata", bus_wdata, exp_wdata);
                seen_we    = bus_we;
                seen_addr  = bus_addr;
                seen_be    = bus_be;
                seen_wdata = bus_wdata;
            end
            if (done) begin
                done_cnt++;
                check("stall_done", stall, 0);
                check("exc_done", exc, exp_exc);
                check("rd_data_done", rd_data, txn_rd);
                if (exp_exc) check("exc_code", exc_code, exp_code);
                seen_code = exc_code;
                held_rd   = txn_rd;
            end else begin
                check("exc_quiet", exc, 0);
                check("rd_data_hold", rd_data, held_rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; width = 2'b00; load_sign = 1'b0;
        addr = '0; wdata = '0; chk_en = 1'b0; held_rd = '0; stray_ready = 1'b0;
        resp_wait = 0; resp_rdata = '0; rcnt = 0;
        exp_req = 0; exp_lat = 0; req_cycles = 0; stall_cycles = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_exc", exc, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_exc_code", exc_code, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        do_txn(1, 2'b01, 0, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, "sh");
        check("sh_addr_lit", seen_addr, 32'h0000_0100);
        check("sh_be_lit", seen_be, 4'b1100);
        check("sh_wdata_lit", seen_wdata, 32'hABCD_ABCD);
        check("sh_we_lit", seen_we, 1);

        do_txn(0, 2'b10, 1, 32'h0000_0003, 32'h0, 32'h80FF_0011, 0, "lb");
        check("lb_lit", rd_data, 32'hFFFF_FF80);
        do_txn(0, 2'b10, 0, 32'h0000_0003, 32'h0, 32'h80FF_0011, 0, "lbu");
        check("lbu_lit", rd_data, 32'h0000_0080);
        do_txn(0, 2'b01, 0, 32'h0000_0002, 32'h0, 32'h80FF_0011, 0, "lhu");
        check("lhu_lit", rd_data, 32'h0000_80FF);

        stray_ready = 1'b1;
        do_txn(0, 2'b01, 1, 32'h0000_0010, 32'h0, 32'h1234_8001, 1, "lh");
        check("lh_lit", rd_data, 32'hFFFF_8001);
        do_txn(0, 2'b00, 0, 32'h0000_0006, 32'h0, 32'h5555_5555, 0, "lw_mis");
        check("lw_mis_code", seen_code, 5'd4);
        check("lw_mis_rd_kept", rd_data, 32'hFFFF_8001);
        do_txn(1, 2'b00, 0, 32'h0000_0001, 32'h0F0F_0F0F, 32'h0, 0, "sw_mis");
        check("sw_mis_code", seen_code, 5'd5);
        do_txn(0, 2'b11, 0, 32'h0000_0008, 32'h0, 32'h0, 0, "width_ill");
        check("ill_code", seen_code, 5'd4);
        stray_ready = 1'b0;

        do_txn(0, 2'b00, 0, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 3, "lw_wait");
        check("lw_wait_rd_lit", rd_data, 32'hCAFE_F00D);
        check("lw_wait_req_lit", req_cycles, 4);
        check("lw_wait_stall_lit", stall_cycles, 5);
        do_txn(1, 2'b00, 0, 32'h0000_2004, 32'h89AB_CDEF, 32'h0, 2, "sw");
        check("sw_rd_kept", rd_data, 32'hCAFE_F00D);
        do_txn(0, 2'b10, 0, 32'h0000_0001, 32'h0, 32'h0000_A500, 0, "lbu1");
        check("lbu1_lit", rd_data, 32'h0000_00A5);

        // Reset in the second REQ cycle abandons the transaction.
        setup(0, 2'b00, 0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        held_rd   = '0;
        resp_wait = 0;
        @(negedge clk);
        check("rst_req_bus_req", bus_req, 0);
        check("rst_req_stall", stall, 0);
        check("rst_req_done", done, 0);
        repeat (2) @(negedge clk);
        check("rst_req_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        do_txn(1, 2'b10, 0, 32'h0000_0005, 32'hAABB_CC5A, 32'h0, 1, "sb");
        check("sb_be_lit", seen_be, 4'b0010);
        check("sb_wdata_lit", seen_wdata, 32'h5A5A_5A5A);

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_txn(0, 2'b00, 0, 32'h0000_0300, 32'h0, 32'h0000_0001, 1000, "lw_timeout");
        check("timeout_code", seen_code, 5'd7);
        check("timeout_rd_kept", rd_data, 32'h0000_0000);
        do_txn(0, 2'b00, 0, 32'h0000_0304, 32'h0, 32'h7777_0001, 0, "lw_after_to");
        check("after_to_lit", rd_data, 32'h7777_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
